// File: rtl/sdram_arbiter.sv
// sdram_arbiter: single owner of the SDRAM pins, muxing init/refresh/write/read
// engines. Optional write/read round-robin enabled by macro SDRAM_ARB_RR_EN.
//
// Ports:
//   arb_clk, arb_rst           clock, async active-high reset
//   init_*, aref_*, wr_*, rd_* engine command/bank/address buses, req/end
//   wr_sdram_en/_data          write engine data drive
//   aref_en, wr_en, rd_en      grants (level while granted)
//   sdram_*                    pad-side command, address, data, cke
module sdram_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2
) (
  input  logic              arb_clk,
  input  logic              arb_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   wr_first;
  logic [3:0] cmd;

`ifdef SDRAM_ARB_RR_EN
  logic last_wr_q, last_wr_d;

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) last_wr_q <= 1'b0;
    else         last_wr_q <= last_wr_d;
  end

  // Read wins a write/read tie only when the last grant went to write.
  assign wr_first = !(rd_req && last_wr_q);

  always_comb begin
    last_wr_d = last_wr_q;
    if (state_q == IDLE && state_d == WRITE) last_wr_d = 1'b1;
    if (state_q == IDLE && state_d == READ)  last_wr_d = 1'b0;
  end
`else
  assign wr_first = 1'b1;
`endif

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) state_q <= INIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:  if (init_end) state_d = IDLE;
      IDLE: begin
        if (aref_req)               state_d = AREF;
        else if (wr_req && wr_first) state_d = WRITE;
        else if (rd_req)            state_d = READ;
        else if (wr_req)            state_d = WRITE;
      end
      AREF:  if (aref_end) state_d = IDLE;
      WRITE: if (wr_end)   state_d = IDLE;
      READ:  if (rd_end)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign aref_en = (state_q == AREF);
  assign wr_en   = (state_q == WRITE);
  assign rd_en   = (state_q == READ);

  // Reset forces NOP even though the state already reads INIT.
  always_comb begin
    cmd        = CMD_NOP;
    sdram_ba   = '1;
    sdram_addr = '1;
    if (!arb_rst) begin
      case (state_q)
        INIT: begin
          cmd = init_cmd; sdram_ba = init_bank; sdram_addr = init_addr;
        end
        AREF: begin
          cmd = aref_cmd; sdram_ba = aref_bank; sdram_addr = aref_addr;
        end
        WRITE: begin
          cmd = wr_cmd; sdram_ba = wr_bank; sdram_addr = wr_addr;
        end
        READ: begin
          cmd = rd_cmd; sdram_ba = rd_bank; sdram_addr = rd_addr;
        end
        default: ;
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  assign sdram_dq_oe  = (state_q == WRITE) && wr_sdram_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;
  assign sdram_cke    = ~arb_rst;

endmodule
